// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the coordinate type shared by the VGA timing block.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_PIPE_DEPTH = 2;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register of DEPTH stages, advancing on ce, with a per-bit reset value loaded into every stage.
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, active-video flag, sync pulses and frame counter.
// Define VGA_TIMING_PIPE_EN to delay blank/hs/vs by PIPE_DEPTH pixels through vga_sync_delay.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int HTOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(HTOT - 1);
  localparam coord_t V_LAST = coord_t'(VTOT - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_FIN = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_FIN = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  if (HTOT > 1024 || VTOT > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DEPTH < 1) begin : g_depth_check
    $error("vga_timing_gen: PIPE_DEPTH must be at least 1");
  end

  coord_t x_nxt, y_nxt;
  logic   blank_nxt, hs_nxt, vs_nxt, fs_nxt, frame_wrap;
  logic   blank_r, hs_r, vs_r;
  // Distinguishes the post-reset entry into (0,0) from a real frame wrap.
  logic   running;

  always_comb begin
    x_nxt = DrawX + coord_t'(1);
    y_nxt = DrawY;
    if (DrawX == H_LAST) begin
      x_nxt = '0;
      y_nxt = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
    end
  end

  // Qualifiers come from the next coordinates so they register alongside them.
  assign frame_wrap = (DrawX == H_LAST) && (DrawY == V_LAST);
  assign blank_nxt  = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  assign hs_nxt     = !((x_nxt >= HS_BEG) && (x_nxt < HS_FIN));
  assign vs_nxt     = !((y_nxt >= VS_BEG) && (y_nxt < VS_FIN));
  assign fs_nxt     = (x_nxt == '0) && (y_nxt == '0);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank_r     <= 1'b0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      running     <= 1'b0;
    end else if (pix_ce) begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank_r     <= blank_nxt;
      hs_r        <= hs_nxt;
      vs_r        <= vs_nxt;
      frame_start <= fs_nxt;
      running     <= 1'b1;
      if (running && frame_wrap) frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  vga_sync_delay #(
    .DEPTH   (PIPE_DEPTH),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .ce    (pix_ce),
    .din   ({hs_r, vs_r, blank_r}),
    .dout  ({hs, vs, blank})
  );
`else
  assign blank = blank_r;
  assign hs    = hs_r;
  assign vs    = vs_r;
`endif

endmodule
